// File: rtl/lsu_pkg.sv
// Shared definitions for the load/store memory master: access-size encodings,
// FSM state enum and the load-lane extension helper.
package lsu_pkg;

  localparam logic [1:0] SIZE_B   = 2'b00;
  localparam logic [1:0] SIZE_H   = 2'b01;
  localparam logic [1:0] SIZE_W   = 2'b10;
  localparam logic [1:0] SIZE_RSV = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_WRITE  = 3'd2,
    ST_RMW_RD = 3'd3,
    ST_RMW_WR = 3'd4,
    ST_RESP   = 3'd5
  } lsu_state_e;

  // Widen a byte (low 8 bits of lane_val) or a half (all 16 bits) to 32 bits,
  // either sign- or zero-extended.
  function automatic logic [31:0] extend_lane(input logic [15:0] lane_val,
                                              input logic        is_byte,
                                              input logic        zero_ext);
    logic [31:0] res;
    if (is_byte) begin
      res = zero_ext ? {24'h000000, lane_val[7:0]} : {{24{lane_val[7]}}, lane_val[7:0]};
    end else begin
      res = zero_ext ? {16'h0000, lane_val} : {{16{lane_val[15]}}, lane_val};
    end
    return res;
  endfunction

endpackage

// File: rtl/lsu_mem_master_lane_align.sv
// Combinational lane handling: extracts and extends the addressed lane of a
// read word for loads, and merges store data into an old word for RMW stores.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [1:0]  size,
  input  logic [1:0]  lane,
  input  logic        uns,
  input  logic [31:0] rdata,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] merge_data
);

  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Select the addressed lane and extend it to a full load result.
  always_comb begin
    byte_s    = rdata[{lane, 3'b000} +: 8];
    half_s    = lane[1] ? rdata[31:16] : rdata[15:0];
    load_data = 32'h0000_0000;
    case (size)
      SIZE_B:  load_data = extend_lane({8'h00, byte_s}, 1'b1, uns);
      SIZE_H:  load_data = extend_lane(half_s, 1'b0, uns);
      SIZE_W:  load_data = rdata;
      default: load_data = 32'h0000_0000;
    endcase
  end

  // Replace the addressed lane of the old word with right-justified store data.
  always_comb begin
    merge_data = rdata;
    case (size)
      SIZE_B: merge_data[{lane, 3'b000} +: 8] = wdata[7:0];
      SIZE_H: begin
        if (lane[1]) begin
          merge_data[31:16] = wdata[15:0];
        end else begin
          merge_data[15:0] = wdata[15:0];
        end
      end
      SIZE_W:  merge_data = wdata;
      default: merge_data = rdata;
    endcase
  end

endmodule

// File: rtl/lsu_mem_master.sv
// Load/store initiator between the CPU pipeline and a word-wide memory without
// byte enables. Sub-word stores run as read-modify-write sequences.
// Build option: LSU_MISALIGN_TRAP_EN -- when defined, misaligned half/word
// requests fault; otherwise they are force-aligned and proceed.
module lsu_mem_master
  import lsu_pkg::*;
#(
  parameter int MEM_WORDS = 256,
  parameter int DATA_W    = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_fault,
  output logic              mem_read,
  output logic              mem_write,
  output logic [31:0]       mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // One past the last legal byte address; 33 bits so large memories cannot wrap.
  localparam logic [32:0] ADDR_LIMIT = 33'(MEM_WORDS) * 33'd4;

  lsu_state_e  state_r;
  lsu_state_e  state_next_s;

  logic        accept_s;
  logic        fault_s;
  logic        misalign_s;
  logic [31:0] addr_aligned_s;

  logic [31:0] addr_r;
  logic [1:0]  size_r;
  logic        we_r;
  logic        uns_r;
  logic [31:0] wdata_r;
  logic [31:0] old_r;

  logic        rsp_valid_r;
  logic [31:0] rsp_rdata_r;
  logic        rsp_fault_r;

  logic [31:0] align_rdata_s;
  logic [31:0] load_data_s;
  logic [31:0] merge_data_s;

  assign accept_s  = req_valid && req_ready;
  assign mem_addr  = {addr_r[31:2], 2'b00};
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign rsp_fault = rsp_fault_r;

  // Alignment policy: either flag misalignment or clear the low address bits.
  always_comb begin
    misalign_s     = 1'b0;
    addr_aligned_s = req_addr;
`ifdef LSU_MISALIGN_TRAP_EN
    if (req_size == SIZE_H) begin
      misalign_s = req_addr[0];
    end else if (req_size == SIZE_W) begin
      misalign_s = (req_addr[1:0] != 2'b00);
    end else begin
      misalign_s = 1'b0;
    end
`else
    if (req_size == SIZE_H) begin
      addr_aligned_s = {req_addr[31:1], 1'b0};
    end else if (req_size == SIZE_W) begin
      addr_aligned_s = {req_addr[31:2], 2'b00};
    end else begin
      addr_aligned_s = req_addr;
    end
`endif
  end

  // A request faults on reserved size, out-of-range address or trapped misalignment.
  always_comb begin
    fault_s = (req_size == SIZE_RSV) || ({1'b0, req_addr} >= ADDR_LIMIT) || misalign_s;
  end

  // Load path reads the live memory word; the RMW write phase merges into the saved word.
  always_comb begin
    if (state_r == ST_RMW_WR) begin
      align_rdata_s = old_r;
    end else begin
      align_rdata_s = mem_rdata;
    end
  end

  lsu_lane_align u_lane_align (
    .size       (size_r),
    .lane       (addr_r[1:0]),
    .uns        (uns_r),
    .rdata      (align_rdata_s),
    .wdata      (wdata_r),
    .load_data  (load_data_s),
    .merge_data (merge_data_s)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (!accept_s) begin
          state_next_s = ST_IDLE;
        end else if (fault_s) begin
          state_next_s = ST_RESP;
        end else if (!req_we) begin
          state_next_s = ST_LOAD;
        end else if (req_size == SIZE_W) begin
          state_next_s = ST_WRITE;
        end else begin
          state_next_s = ST_RMW_RD;
        end
      end
      ST_LOAD:   state_next_s = ST_RESP;
      ST_WRITE:  state_next_s = ST_RESP;
      ST_RMW_RD: state_next_s = ST_RMW_WR;
      ST_RMW_WR: state_next_s = ST_RESP;
      ST_RESP:   state_next_s = ST_IDLE;
      default:   state_next_s = ST_IDLE;
    endcase
  end

  // FSM outputs; memory strobes are suppressed during reset so an RMW cannot complete.
  always_comb begin
    req_ready = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    mem_wdata = 32'h0000_0000;
    case (state_r)
      ST_IDLE:   req_ready = !rst;
      ST_LOAD:   mem_read  = !rst;
      ST_WRITE: begin
        mem_write = !rst;
        mem_wdata = wdata_r;
      end
      ST_RMW_RD: mem_read  = !rst;
      ST_RMW_WR: begin
        mem_write = !rst;
        mem_wdata = merge_data_s;
      end
      ST_RESP:   req_ready = 1'b0;
      default:   req_ready = 1'b0;
    endcase
  end

  // Capture the request on accept; aligned address is stored when alignment is forced.
  always_ff @(posedge clk) begin
    if (rst) begin
      addr_r  <= 32'h0000_0000;
      size_r  <= 2'b00;
      we_r    <= 1'b0;
      uns_r   <= 1'b0;
      wdata_r <= 32'h0000_0000;
    end else if (accept_s) begin
      addr_r  <= addr_aligned_s;
      size_r  <= req_size;
      we_r    <= req_we;
      uns_r   <= req_unsigned;
      wdata_r <= req_wdata;
    end
  end

  // Hold the old memory word between the two halves of an RMW store.
  always_ff @(posedge clk) begin
    if (rst) begin
      old_r <= 32'h0000_0000;
    end else if (state_r == ST_RMW_RD) begin
      old_r <= mem_rdata;
    end
  end

  // Response registers: strobe in RESP, data only from a completed load.
  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= 32'h0000_0000;
      rsp_fault_r <= 1'b0;
    end else begin
      rsp_valid_r <= (state_next_s == ST_RESP);
      if (accept_s) begin
        rsp_rdata_r <= 32'h0000_0000;
        rsp_fault_r <= fault_s;
      end else if ((state_r == ST_LOAD) && !we_r) begin
        rsp_rdata_r <= load_data_s;
      end
    end
  end

endmodule
